sdram_mport_arb: RTL and testbench

Parametrised multi-channel front-end arbiter placed between per-channel write/read FIFO controllers and `sdram_controller`. It replaces the single write port plus single read port arrangement with NCH channels. Each channel has an independent write region and an independent read region. The block issues one burst at a time to the controller and grants the 2*NCH request slots in round-robin order. It keeps a wrapping SDRAM address pointer per slot and drives one-hot grant vectors, which the data-path muxes use to select the active channel.

---
 rtl/sdram_mport_arb.sv | 235 +++++++++++++++++++++++
 tb/tb_sdram_mport_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_mport_arb.sv
// sdram_mport_arb: round-robin burst arbiter for 2*NCH SDRAM request slots.
// Optional ack watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_mport_arb #(
    parameter int NCH     = 4,
    parameter int AW      = 24,
    parameter int LW      = 10,
    parameter int TMO_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic [NCH-1:0]    ch_wr_pend,
    input  logic [NCH-1:0]    ch_rd_pend,
    input  logic [NCH*AW-1:0] ch_wr_min,
    input  logic [NCH*AW-1:0] ch_wr_max,
    input  logic [NCH*AW-1:0] ch_rd_min,
    input  logic [NCH*AW-1:0] ch_rd_max,
    input  logic [NCH*LW-1:0] ch_wr_len,
    input  logic [NCH*LW-1:0] ch_rd_len,
    input  logic [NCH-1:0]    ch_wr_load,
    input  logic [NCH-1:0]    ch_rd_load,
    output logic [NCH-1:0]    ch_wr_grant,
    output logic [NCH-1:0]    ch_rd_grant,
    output logic              sdram_wr_req,
    input  logic              sdram_wr_ack,
    output logic [AW-1:0]     sdram_wr_addr,
    output logic [LW-1:0]     sdram_wr_burst,
    output logic              sdram_rd_req,
    input  logic              sdram_rd_ack,
    output logic [AW-1:0]     sdram_rd_addr,
    output logic [LW-1:0]     sdram_rd_burst,
    output logic              arb_err
);

    localparam int NS = 2 * NCH;
    localparam int SW = $clog2(NS);

    typedef enum logic [1:0] {IDLE, REQ, BUSY, UPD} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] rr_q, rr_d;
    logic [AW-1:0] ptr_q [NS];
    logic [NS-1:0] rld_q;

    logic [AW-1:0] s_min  [NS];
    logic [AW-1:0] s_max  [NS];
    logic [LW-1:0] s_len  [NS];
    logic [NS-1:0] s_pend;
    logic [NS-1:0] s_load;
    logic [NS-1:0] elig;

    logic [SW-1:0] win;
    logic          found;
    logic [SW:0]   t;

    logic [AW-1:0] cur_ptr;
    logic [LW-1:0] cur_len;
    logic          cur_ack;
    logic [AW:0]   nxt;
    logic [AW+1:0] nxt2;
    logic [AW-1:0] upd_ptr;
    logic          act;
    logic [NS-1:0] slot_gnt;
    logic          tmo;
    logic          skip;

    // Unpack per-channel buses into slot order wr0, rd0, wr1, rd1, ...
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            s_min[2*i]    = ch_wr_min[i*AW +: AW];
            s_max[2*i]    = ch_wr_max[i*AW +: AW];
            s_len[2*i]    = ch_wr_len[i*LW +: LW];
            s_pend[2*i]   = ch_wr_pend[i];
            s_load[2*i]   = ch_wr_load[i];
            s_min[2*i+1]  = ch_rd_min[i*AW +: AW];
            s_max[2*i+1]  = ch_rd_max[i*AW +: AW];
            s_len[2*i+1]  = ch_rd_len[i*LW +: LW];
            s_pend[2*i+1] = ch_rd_pend[i];
            s_load[2*i+1] = ch_rd_load[i];
        end
    end

    assign elig  = s_pend & {NS{sdram_init_done}};
    assign found = |elig;

    // Rotating-priority search; the smallest offset from rr_q+1 wins.
    always_comb begin
        win = '0;
        t   = '0;
        for (int k = NS; k >= 1; k--) begin
            t = {1'b0, rr_q} + (SW+1)'(k);
            if (t >= (SW+1)'(NS)) begin
                t = t - (SW+1)'(NS);
            end
            if (elig[t[SW-1:0]]) begin
                win = t[SW-1:0];
            end
        end
    end

    // Next pointer for the served slot, wrapping when another burst would not fit.
    always_comb begin
        cur_ptr = ptr_q[sel_q];
        cur_len = s_len[sel_q];
        cur_ack = sel_q[0] ? sdram_rd_ack : sdram_wr_ack;
        nxt     = {1'b0, cur_ptr} + {{(AW+1-LW){1'b0}}, cur_len};
        nxt2    = {1'b0, nxt} + {{(AW+2-LW){1'b0}}, cur_len};
        if (nxt2 > {2'b00, s_max[sel_q]}) begin
            upd_ptr = s_min[sel_q];
        end else begin
            upd_ptr = nxt[AW-1:0];
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;

    assign tmo = ((state_q == REQ) || (state_q == BUSY)) &&
                 (cnt_q == CW'(TMO_CYC - 1));
    assign cnt_d = ((state_q == REQ) || (state_q == BUSY)) ?
                   cnt_q + CW'(1) : '0;

    // Watchdog counter and one-cycle abort flag (high during the forced UPD).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= tmo;
        end
    end

    assign skip    = err_q;
    assign arb_err = err_q;
`else
    assign tmo     = 1'b0;
    assign skip    = 1'b0;
    assign arb_err = 1'b0;
`endif

    // FSM state, served slot and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= SW'(NS - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
        end
    end

    // Next-state logic: select, request, wait for burst end, update.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = REQ;
                    sel_d   = win;
                end
            end
            REQ: begin
                if (tmo) begin
                    state_d = UPD;
                end else if (cur_ack) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (tmo || !cur_ack) begin
                    state_d = UPD;
                end
            end
            UPD: begin
                state_d = IDLE;
                rr_d    = sel_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-slot address pointers; loads on the active slot wait for UPD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                ptr_q[i] <= '0;
            end
            rld_q <= '1;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if ((state_q == IDLE) || (sel_q != SW'(i))) begin
                    if (s_load[i] || rld_q[i]) begin
                        ptr_q[i] <= s_min[i];
                        rld_q[i] <= 1'b0;
                    end
                end else if (state_q == UPD) begin
                    if (s_load[i] || rld_q[i]) begin
                        ptr_q[i] <= s_min[i];
                    end else if (!skip) begin
                        ptr_q[i] <= upd_ptr;
                    end
                    rld_q[i] <= 1'b0;
                end else if (s_load[i]) begin
                    rld_q[i] <= 1'b1;
                end
            end
        end
    end

    // Controller requests and grants decoded from the registered state.
    always_comb begin
        act            = (state_q == REQ) || (state_q == BUSY);
        slot_gnt       = act ? (NS'(1) << sel_q) : '0;
        sdram_wr_req   = (state_q == REQ) && !sel_q[0];
        sdram_rd_req   = (state_q == REQ) && sel_q[0];
        sdram_wr_addr  = (act && !sel_q[0]) ? cur_ptr : '0;
        sdram_wr_burst = (act && !sel_q[0]) ? cur_len : '0;
        sdram_rd_addr  = (act && sel_q[0]) ? cur_ptr : '0;
        sdram_rd_burst = (act && sel_q[0]) ? cur_len : '0;
        for (int i = 0; i < NCH; i++) begin
            ch_wr_grant[i] = slot_gnt[2*i];
            ch_rd_grant[i] = slot_gnt[2*i+1];
        end
    end

endmodule

// File: tb/tb_sdram_mport_arb.sv
// tb_sdram_mport_arb: directed bench for sdram_mport_arb (NCH=4).
// Timeout checks run only when SDRAM_ARB_TIMEOUT_EN is defined.
module tb_sdram_mport_arb;

    localparam int NCH = 4;
    localparam int AW  = 24;
    localparam int LW  = 10;

    logic              clk;
    logic              rst_n;
    logic              init;
    logic [NCH-1:0]    wr_pend, rd_pend, wr_load, rd_load;
    logic [NCH*AW-1:0] wr_min_b, wr_max_b, rd_min_b, rd_max_b;
    logic [NCH*LW-1:0] wr_len_b, rd_len_b;
    logic [NCH-1:0]    wr_grant, rd_grant;
    logic              wr_req, wr_ack, rd_req, rd_ack, arb_err;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [LW-1:0]     wr_burst, rd_burst;

    logic [23:0] wmin [4];
    logic [23:0] wmax [4];
    logic [23:0] rmin [4];
    logic [23:0] rmax [4];
    logic [9:0]  wlen [4];
    logic [9:0]  rlen [4];

    int n_chk = 0;
    int n_err = 0;
    int viol  = 0;
    int n_abort = 0;
    int w;
    int c;
    int nreq;

    sdram_mport_arb #(
        .NCH(NCH), .AW(AW), .LW(LW), .TMO_CYC(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sdram_init_done(init),
        .ch_wr_pend(wr_pend), .ch_rd_pend(rd_pend),
        .ch_wr_min(wr_min_b), .ch_wr_max(wr_max_b),
        .ch_rd_min(rd_min_b), .ch_rd_max(rd_max_b),
        .ch_wr_len(wr_len_b), .ch_rd_len(rd_len_b),
        .ch_wr_load(wr_load), .ch_rd_load(rd_load),
        .ch_wr_grant(wr_grant), .ch_rd_grant(rd_grant),
        .sdram_wr_req(wr_req), .sdram_wr_ack(wr_ack),
        .sdram_wr_addr(wr_addr), .sdram_wr_burst(wr_burst),
        .sdram_rd_req(rd_req), .sdram_rd_ack(rd_ack),
        .sdram_rd_addr(rd_addr), .sdram_rd_burst(rd_burst),
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    // Protocol invariants sampled every falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_req && rd_req) viol++;
            if ($countones({rd_grant, wr_grant}) > 1) viol++;
            if ((wr_req || rd_req) && ({rd_grant, wr_grant} == 8'h00)) viol++;
            if (arb_err) n_abort++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] smin(input int s);
        return (s % 2) ? 32'(rmin[s/2]) : 32'(wmin[s/2]);
    endfunction

    function automatic logic [31:0] slen(input int s);
        return (s % 2) ? 32'(rlen[s/2]) : 32'(wlen[s/2]);
    endfunction

    task automatic apply_cfg();
        for (int i = 0; i < NCH; i++) begin
            wr_min_b[i*AW +: AW] = wmin[i];
            wr_max_b[i*AW +: AW] = wmax[i];
            rd_min_b[i*AW +: AW] = rmin[i];
            rd_max_b[i*AW +: AW] = rmax[i];
            wr_len_b[i*LW +: LW] = wlen[i];
            rd_len_b[i*LW +: LW] = rlen[i];
        end
    endtask

    // Wait for a request, check slot/addr/burst, then play controller ack.
    task automatic serve(input int s, input logic [31:0] ea,
                         input logic [31:0] el, input int dly,
                         input int hold, input bit ld, output int wt);
        int ch;
        bit rd;
        ch = s / 2;
        rd = (s % 2) == 1;
        wt = 0;
        while (!(wr_req || rd_req) && wt < 60) begin
            @(negedge clk);
            wt++;
        end
        if (!(wr_req || rd_req)) begin
            chk("req_wait", 0, 1);
            return;
        end
        chk("dir", {30'd0, rd_req, wr_req}, rd ? 32'd2 : 32'd1);
        chk("grant", {24'd0, rd_grant, wr_grant},
            rd ? (32'h10 << ch) : (32'h1 << ch));
        chk("addr", rd ? 32'(rd_addr) : 32'(wr_addr), ea);
        chk("burst", rd ? 32'(rd_burst) : 32'(wr_burst), el);
        repeat (dly) @(negedge clk);
        if (rd) rd_ack = 1'b1;
        else wr_ack = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (ld && k == 0) wr_load[0] = 1'b1;
            if (ld && k == 1) begin
                wr_load[0] = 1'b0;
                chk("ld_busy_addr", 32'(wr_addr), ea);
            end
        end
        wr_ack = 1'b0;
        rd_ack = 1'b0;
    endtask

    initial begin
        clk = 0; rst_n = 0; init = 0;
        wr_pend = '0; rd_pend = '0; wr_load = '0; rd_load = '0;
        wr_ack = 0; rd_ack = 0;
        for (int i = 0; i < NCH; i++) begin
            wmin[i] = (i == 0) ? 24'h000100 : 24'(32'h1000 * (i + 1));
            wmax[i] = (i == 0) ? 24'h000130 : wmin[i] + 24'h100;
            wlen[i] = (i == 0) ? 10'd16 : 10'(8 + i);
            rmin[i] = 24'(32'h8000 + 32'h1000 * i);
            rmax[i] = rmin[i] + 24'h100;
            rlen[i] = 10'(4 + i);
        end
        apply_cfg();

        repeat (3) @(negedge clk);
        chk("rst_req", {30'd0, rd_req, wr_req}, 0);
        chk("rst_gnt", {24'd0, rd_grant, wr_grant}, 0);
        chk("rst_waddr", 32'(wr_addr), 0);
        chk("rst_rburst", 32'(rd_burst), 0);
        chk("rst_err", 32'(arb_err), 0);
        rst_n = 1;

        wr_pend = '1; rd_pend = '1;
        nreq = 0;
        repeat (100) begin
            @(negedge clk);
            if (wr_req || rd_req) nreq++;
        end
        chk("no_init_req", nreq, 0);
        init = 1;

        for (int s = 0; s < 8; s++) serve(s, smin(s), slen(s), 1, 8, 0, w);
        serve(0, 32'h110, 16, 1, 8, 1, w);
        for (int s = 1; s < 8; s++)
            serve(s, smin(s) + slen(s), slen(s), 1, 8, 0, w);
        serve(0, 32'h100, 16, 1, 8, 0, w);

        wr_pend = 4'b0001; rd_pend = '0;
        serve(0, 32'h110, 16, 0, 2, 0, w); chk("gap1", w, 3);
        serve(0, 32'h120, 16, 0, 2, 0, w); chk("gap2", w, 3);
        serve(0, 32'h100, 16, 0, 2, 0, w); chk("gap3", w, 3);
        wr_pend = '0;
        repeat (5) @(negedge clk);

        rd_pend[2] = 1'b1;
        w = 0;
        while (!(wr_req || rd_req) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rd2_lat", w, 1);
        chk("rd2_req", {30'd0, rd_req, wr_req}, 2);
        chk("rd2_gnt", {24'd0, rd_grant, wr_grant}, 32'h40);
        chk("rd2_addr", 32'(rd_addr), 32'hA00C);
        chk("rd2_burst", 32'(rd_burst), 6);
        repeat (3) @(negedge clk);
        chk("rd2_req_hold", 32'(rd_req), 1);
        rd_ack = 1'b1;
        @(negedge clk);
        chk("rd2_req_drop", 32'(rd_req), 0);
        chk("rd2_gnt_busy", {24'd0, rd_grant, wr_grant}, 32'h40);
        chk("rd2_addr_busy", 32'(rd_addr), 32'hA00C);
        repeat (3) @(negedge clk);
        rd_ack = 1'b0;
        rd_pend[2] = 1'b0;
        chk("rd2_gnt_ackfall", {24'd0, rd_grant, wr_grant}, 32'h40);
        @(negedge clk);
        chk("rd2_gnt_upd", {24'd0, rd_grant, wr_grant}, 0);

        repeat (4) @(negedge clk);
        rd_load[2] = 1'b1;
        @(negedge clk);
        rd_load[2] = 1'b0;
        repeat (2) @(negedge clk);
        rd_pend[2] = 1'b1;
        serve(5, 32'hA000, 6, 1, 2, 0, w);
        rd_pend[2] = 1'b0;

        wmax[3] = 24'h004004;
        apply_cfg();
        wr_pend[3] = 1'b1;
        serve(6, 32'h4016, 11, 0, 2, 0, w);
        serve(6, 32'h4000, 11, 0, 2, 0, w);
        serve(6, 32'h4000, 11, 0, 2, 0, w);
        wr_pend[3] = 1'b0;
        repeat (4) @(negedge clk);

`ifdef SDRAM_ARB_TIMEOUT_EN
        wr_pend[1] = 1'b1;
        w = 0;
        while (!wr_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("tmo_addr", 32'(wr_addr), 32'h2012);
        c = 0;
        while (!arb_err && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("tmo_cycles", c, 15);
        chk("tmo_gnt", {24'd0, rd_grant, wr_grant}, 0);
        rd_pend[1] = 1'b1;
        serve(3, 32'h900A, 5, 1, 2, 0, w);
        rd_pend[1] = 1'b0;
        serve(2, 32'h2012, 9, 1, 2, 0, w);
        wr_pend[1] = 1'b0;
        repeat (4) @(negedge clk);
`endif

        wr_pend[0] = 1'b1;
        w = 0;
        while (!wr_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        wr_ack = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_req", {30'd0, rd_req, wr_req}, 0);
        chk("arst_gnt", {24'd0, rd_grant, wr_grant}, 0);
        chk("arst_addr", 32'(wr_addr), 0);
        chk("arst_burst", 32'(wr_burst), 0);
        wr_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        serve(0, 32'h100, 16, 1, 2, 0, w);
        wr_pend = '0;
        repeat (4) @(negedge clk);

        chk("invariants", viol, 0);
`ifdef SDRAM_ARB_TIMEOUT_EN
        chk("abort_pulses", n_abort, 1);
`else
        chk("abort_pulses", n_abort, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
